// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect slave port and a register-file endpoint.
// The master modport is the interconnect (or a bench) side; the slave modport is the responder.
interface axil_slave_regfile_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    // write address channel
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;

    // write data channel
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;

    // write response channel
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;

    // read address channel
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;

    // read data channel
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite register file endpoint: NUM_RW read/write control registers followed by
// NUM_RO read-only status registers. One outstanding write and one outstanding read;
// the two paths run independently. Writes to RO or unmapped addresses answer SLVERR.
module axil_slave_regfile #(
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = AXI_ADDR_WIDTH'(32'h1000_0000),
    parameter int                        NUM_RW          = 16,
    parameter int                        NUM_RO          = 4
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    axil_slave_regfile_if.slave                      s_axil,
    output logic [NUM_RW-1:0][AXI_DATA_WIDTH-1:0]    reg_q,
    output logic [NUM_RW-1:0]                        reg_wr_pulse,
    input  logic [NUM_RO-1:0][AXI_DATA_WIDTH-1:0]    hw_status
);

    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    localparam logic [AXI_ADDR_WIDTH-1:0] NUM_RW_A  = AXI_ADDR_WIDTH'(NUM_RW);
    localparam logic [AXI_ADDR_WIDTH-1:0] NUM_ALL_A = AXI_ADDR_WIDTH'(NUM_RW + NUM_RO);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register index of an address relative to the base; wraps modulo 2^AXI_ADDR_WIDTH,
    // so addresses below the base produce huge indices and are rejected by the base check.
    function automatic logic [AXI_ADDR_WIDTH-1:0] addr_to_idx(
        input logic [AXI_ADDR_WIDTH-1:0] addr
    );
        logic [AXI_ADDR_WIDTH-1:0] local_off;
        local_off = addr - AXI_ADDR_OFFSET;
        return local_off >> ADDR_LSB;
    endfunction

    // An address hits only when it is at or above the base and inside the register map.
    function automatic logic addr_is_hit(
        input logic [AXI_ADDR_WIDTH-1:0] addr
    );
        return (addr >= AXI_ADDR_OFFSET) && (addr_to_idx(addr) < NUM_ALL_A);
    endfunction

    // write-path holding registers
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic                      aw_held;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic                      w_held;

    // readiness comes up on the first edge after reset release
    logic                      ready_init;

    // write decode of the held address
    logic [AXI_ADDR_WIDTH-1:0] w_idx;
    logic                      w_hit;
    logic                      w_is_rw;
    logic                      commit;
    logic                      commit_rw;
    logic [AXI_DATA_WIDTH-1:0] w_mask;

    // read decode of the presented address
    logic [AXI_ADDR_WIDTH-1:0] ar_idx;
    logic                      ar_hit;
    logic [AXI_DATA_WIDTH-1:0] rdata_next;
    logic [1:0]                rresp_next;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = s_axil.awvalid & s_axil.awready;
    assign w_hs  = s_axil.wvalid  & s_axil.wready;
    assign b_hs  = s_axil.bvalid  & s_axil.bready;
    assign ar_hs = s_axil.arvalid & s_axil.arready;
    assign r_hs  = s_axil.rvalid  & s_axil.rready;

    assign w_idx     = addr_to_idx(aw_addr_q);
    assign w_hit     = addr_is_hit(aw_addr_q);
    assign w_is_rw   = w_hit && (w_idx < NUM_RW_A);
    assign commit    = aw_held && w_held && !s_axil.bvalid;
    assign commit_rw = commit && w_is_rw;

    assign ar_idx = addr_to_idx(s_axil.araddr);
    assign ar_hit = addr_is_hit(s_axil.araddr);

    // Expand the held byte strobes into a bit mask for the read-modify-write merge.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_mask[b*8 +: 8] = {8{w_strb_q[b]}};
        end
    end

    // Write-path handshake control: capture AW and W independently, commit once both are
    // held and no response is pending, then reopen both channels on the B handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_init     <= 1'b0;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            s_axil.bvalid  <= 1'b0;
            s_axil.bresp   <= 2'b00;
            aw_addr_q      <= '0;
            aw_held        <= 1'b0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            w_held         <= 1'b0;
        end else begin
            if (!ready_init) begin
                ready_init     <= 1'b1;
                s_axil.awready <= 1'b1;
                s_axil.wready  <= 1'b1;
            end

            if (aw_hs) begin
                aw_addr_q      <= s_axil.awaddr;
                aw_held        <= 1'b1;
                s_axil.awready <= 1'b0;
            end

            if (w_hs) begin
                w_data_q      <= s_axil.wdata;
                w_strb_q      <= s_axil.wstrb;
                w_held        <= 1'b1;
                s_axil.wready <= 1'b0;
            end

            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil.bvalid <= 1'b1;
                s_axil.bresp  <= w_is_rw ? RESP_OKAY : RESP_SLVERR;
            end

            if (b_hs) begin
                s_axil.bvalid  <= 1'b0;
                s_axil.awready <= 1'b1;
                s_axil.wready  <= 1'b1;
            end
        end
    end

    // RW register bank: byte-lane merge on commit plus a one-cycle write pulse per register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reg_q        <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit_rw) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_idx == AXI_ADDR_WIDTH'(i)) begin
                        reg_q[i]        <= (reg_q[i] & ~w_mask) | (w_data_q & w_mask);
                        reg_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read data selection for the address currently presented on AR.
    always_comb begin
        rdata_next = '0;
        rresp_next = RESP_SLVERR;
        if (ar_hit) begin
            rresp_next = RESP_OKAY;
            for (int i = 0; i < NUM_RW; i++) begin
                if (ar_idx == AXI_ADDR_WIDTH'(i)) begin
                    rdata_next = reg_q[i];
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (ar_idx == AXI_ADDR_WIDTH'(NUM_RW + j)) begin
                    rdata_next = hw_status[j];
                end
            end
        end
    end

    // Read path: register the response on the AR handshake, hold it until the R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b0;
            s_axil.rdata   <= '0;
            s_axil.rresp   <= 2'b00;
        end else begin
            if (!ready_init) begin
                s_axil.arready <= 1'b1;
            end

            if (ar_hs) begin
                s_axil.arready <= 1'b0;
                s_axil.rvalid  <= 1'b1;
                s_axil.rdata   <= rdata_next;
                s_axil.rresp   <= rresp_next;
            end

            if (r_hs) begin
                s_axil.rvalid  <= 1'b0;
                s_axil.arready <= 1'b1;
            end
        end
    end

endmodule
